// File: rtl/pipe_fixed_point_square.sv
// Pipelined signed fixed-point squarer: out = in*in, resized from 2*WIF fraction bits to WOI.WOF.
// Latency WII+WIF+2 clocks, one sample per clock.
// No backpressure; i_valid=0 slots travel through as o_valid=0 bubbles.
module pipe_fixed_point_square #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [WII+WIF-1:0]   in,
  output logic                 o_valid,
  output logic [WOI+WOF-1:0]   out,
  output logic                 upflow,
  output logic                 downflow
);

  localparam int N  = WII + WIF;   // input width
  localparam int AW = 2 * N;       // exact square width, 2*WIF fraction bits
  localparam int WO = WOI + WOF;   // output width
  localparam int EW = AW + WO + 2; // headroom for zero-padding and the rounding carry

  localparam logic [EW-1:0] MAXV = (EW'(1) << (WO - 1)) - EW'(1);

  // Stage registers: mag/acc/valid for stage 0..N; the last stage needs no magnitude
  logic [N-1:0]  mag_q [0:N-1];
  logic [AW-1:0] acc_q [0:N];
  logic [N:0]    vld_q;

  // Absolute value; the most negative input maps to 2^(N-1), which still fits unsigned
  logic [N-1:0] mag_in;
  assign mag_in = in[N-1] ? (~in + N'(1)) : in;

  // Advance every shift-add stage; stage j adds the partial product for magnitude bit j-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int j = 0; j < N; j++) mag_q[j] <= '0;
      for (int j = 0; j <= N; j++) acc_q[j] <= '0;
    end else begin
      mag_q[0] <= mag_in;
      acc_q[0] <= '0;
      vld_q    <= {vld_q[N-1:0], i_valid};
      for (int j = 1; j < N; j++) mag_q[j] <= mag_q[j-1];
      for (int j = 1; j <= N; j++) begin
        acc_q[j] <= acc_q[j-1] +
                    (mag_q[j-1][j-1] ? (AW'(mag_q[j-1]) << (j - 1)) : AW'(0));
      end
    end
  end

  // Align the exact square to WOF fraction bits (pad, or round/truncate dropped LSBs)
  logic [EW-1:0] acc_ext;
  logic [EW-1:0] val;
  assign acc_ext = EW'(acc_q[N]);

  generate
    if (WOF >= 2 * WIF) begin : g_pad
      assign val = acc_ext << (WOF - 2 * WIF);
    end else begin : g_drop
      localparam int D = 2 * WIF - WOF;
      localparam logic [EW-1:0] RND = (ROUND != 0) ? (EW'(1) << (D - 1)) : EW'(0);
      assign val = (acc_ext + RND) >> D;
    end
  endgenerate

  logic          up_c;
  logic          dn_c;
  logic [WO-1:0] res_c;

  // Range check, optional saturation, and underflow detection on the resized value
  always_comb begin
    up_c  = 1'b0;
    res_c = val[WO-1:0];
    if (val > MAXV) begin
      up_c = 1'b1;
      if (ROOF != 0) res_c = MAXV[WO-1:0];
    end
    dn_c = (acc_q[N] != '0) && (res_c == '0);
  end

  // Output register; flags are qualified so they read 0 in bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid  <= 1'b0;
      out      <= '0;
      upflow   <= 1'b0;
      downflow <= 1'b0;
    end else begin
      o_valid  <= vld_q[N];
      out      <= res_c;
      upflow   <= vld_q[N] & up_c;
      downflow <= vld_q[N] & dn_c;
    end
  end

endmodule

// File: tb/tb_pipe_fixed_point_square.sv
// Directed test of pipe_fixed_point_square: three instances share the stimulus
// (default ROOF=1/ROUND=1, ROOF=0, ROUND=0) and are compared against hand-computed values.
module tb_pipe_fixed_point_square;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [15:0] in;

  logic        ov_a, up_a, dn_a;
  logic [15:0] out_a;
  logic        ov_b, up_b, dn_b;
  logic [15:0] out_b;
  logic        ov_c, up_c, dn_c;
  logic [15:0] out_c;

  int checks;
  int failures;

  // Default configuration: saturate and round
  pipe_fixed_point_square u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .in(in),
    .o_valid(ov_a), .out(out_a), .upflow(up_a), .downflow(dn_a)
  );

  // Wrap on overflow
  pipe_fixed_point_square #(.ROOF(0)) u_wrap (
    .clk(clk), .rst(rst), .i_valid(i_valid), .in(in),
    .o_valid(ov_b), .out(out_b), .upflow(up_b), .downflow(dn_b)
  );

  // Truncate instead of round
  pipe_fixed_point_square #(.ROUND(0)) u_trunc (
    .clk(clk), .rst(rst), .i_valid(i_valid), .in(in),
    .o_valid(ov_c), .out(out_c), .upflow(up_c), .downflow(dn_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one sample for one cycle, then count edges until u_dut raises o_valid.
  // The capture edge is edge 1, so the expected count is 18.
  task automatic single(input logic [15:0] v, output int lat);
    i_valid = 1'b1;
    in      = v;
    lat     = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) i_valid = 1'b0;
      if (ov_a) begin
        lat = k;
        break;
      end
    end
  endtask

  // Wait (bounded) for u_dut o_valid, sampled 1 time unit after the edge
  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ov_a) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  int          lat;
  bit          seen;
  logic [15:0] exp_stream [3];
  logic [15:0] seq_in [3];
  int          stray;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    i_valid  = 1'b0;
    in       = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_ovalid", {29'd0, ov_a, ov_b, ov_c}, 32'd0);
    check("reset_out", {out_a, out_c}, 32'd0);
    check("reset_flags", {26'd0, up_a, dn_a, up_b, dn_b, up_c, dn_c}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single sample: 3.0^2 = 9.0, latency 18
    single(16'h0300, lat);
    check("lat_3p0", lat, 18);
    check("out_3p0", out_a, 16'h0900);
    check("flags_3p0", {up_a, dn_a}, 2'b00);
    @(posedge clk); #1;
    check("ovalid_drop_3p0", ov_a, 1'b0);

    // Back-to-back: -1.5, 1.5, 0 -> 2.25, 2.25, 0
    seq_in[0] = 16'hFE80; seq_in[1] = 16'h0180; seq_in[2] = 16'h0000;
    exp_stream[0] = 16'h0240; exp_stream[1] = 16'h0240; exp_stream[2] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      in      = seq_in[k];
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    in      = 16'h0000;
    wait_valid(seen);
    check("stream_seen", seen, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stream_valid%0d", k), ov_a, 1'b1);
      check($sformatf("stream_out%0d", k), out_a, exp_stream[k]);
      check($sformatf("stream_flags%0d", k), {up_a, dn_a}, 2'b00);
      @(posedge clk); #1;
    end
    check("stream_end", ov_a, 1'b0);

    // Overflow 12.0^2 = 144: saturate vs wrap
    single(16'h0C00, lat);
    check("lat_12", lat, 18);
    check("sat_out_12", out_a, 16'h7FFF);
    check("sat_up_12", up_a, 1'b1);
    check("wrap_out_12", out_b, 16'h9000);
    check("wrap_up_12", up_b, 1'b1);

    // Most negative input: (-128)^2 = 16384
    single(16'h8000, lat);
    check("sat_out_m128", out_a, 16'h7FFF);
    check("sat_up_m128", up_a, 1'b1);
    check("wrap_out_m128", out_b, 16'h0000);
    check("wrap_up_m128", up_b, 1'b1);

    // 0x000C^2 = 144/65536: rounds to 1 LSB, truncates to 0
    single(16'h000C, lat);
    check("round_out_c", out_a, 16'h0001);
    check("round_dn_c", dn_a, 1'b0);
    check("trunc_out_c", out_c, 16'h0000);
    check("trunc_dn_c", dn_c, 1'b1);

    // Smallest nonzero input underflows under both settings
    single(16'h0001, lat);
    check("round_1lsb", {out_a, 15'd0, dn_a}, {16'h0000, 15'd0, 1'b1});
    check("trunc_1lsb", {out_c, 15'd0, dn_c}, {16'h0000, 15'd0, 1'b1});

    // Bubbles: valid slots carry 1.0, invalid slots carry an overflowing 12.0
    for (int k = 0; k < 8; k++) begin
      i_valid = (k % 2 == 0);
      in      = (k % 2 == 0) ? 16'h0100 : 16'h0C00;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    in      = 16'h0100;
    wait_valid(seen);
    check("bubble_seen", seen, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bubble_valid%0d", k), ov_a, (k % 2 == 0));
      if (k % 2 == 0) check($sformatf("bubble_out%0d", k), out_a, 16'h0100);
      check($sformatf("bubble_flags%0d", k), {up_a, dn_a, up_b, dn_b}, 4'b0000);
      @(posedge clk); #1;
    end

    // Reset mid-stream: 5 samples, reset 3 clocks later, nothing emerges
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      in      = 16'h0300;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_out", {out_a, out_b}, 32'd0);
    check("async_rst_flags", {ov_a, up_a, dn_a}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (ov_a || ov_b || ov_c) stray++;
    end
    check("flushed_no_valid", stray, 0);

    // Sample after release: 2.0^2 = 4.0
    single(16'h0200, lat);
    check("lat_post_rst", lat, 18);
    check("out_post_rst", out_a, 16'h0400);
    check("flags_post_rst", {up_a, dn_a}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_fixed_point_square.md
Name: pipe_fixed_point_square

Overview:
- Pipelined signed fixed-point squarer; the forward counterpart of the team's pipelined square-root block.
- Computes out = in*in for a two's-complement WII.WIF input using one shift-add stage per input magnitude bit.
- Resizes the result to WOI.WOF with optional saturation and rounding.
- Accepts one sample per clock; used to re-square sqrt results in the verification loop and in norm/energy datapaths.

Parameters:
- WII, 8, integer bits of input, including sign.
- WIF, 8, fractional bits of input.
- WOI, 8, integer bits of output, including sign.
- WOF, 8, fractional bits of output.
- ROOF, 1, 1 = saturate to max positive on overflow; 0 = keep low WOI+WOF bits.
- ROUND, 1, 1 = round half up when dropping fractional bits; 0 = truncate (floor).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- i_valid, input, 1, qualifies in for this cycle.
- in, input, WII+WIF, signed fixed-point operand.
- o_valid, output, 1, qualifies out/upflow/downflow.
- out, output, WOI+WOF, signed fixed-point square, resized.
- upflow, output, 1, exact square exceeds output range.
- downflow, output, 1, exact square nonzero but out == 0.

Behaviour:
- Reset:
  - The asynchronous rst assertion clears every pipeline register, including valid bits, magnitudes and accumulators.
  - out, o_valid, upflow and downflow read 0 during reset and until real data drains through.
  - Asserting reset mid-stream discards all in-flight samples; no o_valid pulse results from them.
- Latency and throughput:
  - Latency is fixed: sample presented at edge k appears with o_valid=1 after edge k+WII+WIF+1, i.e. WII+WIF+2 register stages.
  - Throughput is 1/clk. There is no stall or back-pressure.
  - i_valid=0 slots propagate as o_valid=0 bubbles. Data registers may hold don't-care values in bubbles; flags must be 0 when o_valid=0.
- Stage 0:
  - Register mag = |in| as unsigned WII+WIF bits. The most negative input 1000..0 gives mag 2^(WII+WIF-1), which is exact and does not overflow.
  - Register acc=0 and i_valid.
- Stages 1..WII+WIF (stage j handles mag bit j-1):
  - acc += mag[j-1] ? (mag << (j-1)) : 0.
  - Carry mag and valid forward.
  - acc is 2*(WII+WIF) bits unsigned with 2*WIF fractional bits; no overflow is possible.
- Final stage (resize to WOI.WOF, registered):
  - If WOF >= 2*WIF: left-shift by WOF-2*WIF (zero pad).
  - Else drop D = 2*WIF-WOF LSBs. With ROUND=1, add 1 at bit D-1 before dropping.
  - Max representable = 2^(WOI+WOF-1)-1 LSBs.
  - If the (rounded) value exceeds max: upflow=1; out = max if ROOF=1, else the low WOI+WOF bits.
  - downflow=1 iff acc != 0 and the resized out == 0 (only reachable when bits are dropped).
  - Result is always >= 0; the sign bit of out is 0 except when ROOF=0 wraps.
- Zero input gives out=0, upflow=0, downflow=0.

Test Plan (defaults 8.8 -> 8.8, latency 18 clocks):
- Single sample: in=0x0300 (3.0), i_valid one cycle -> exactly 18 edges later o_valid=1, out=0x0900, upflow=0, downflow=0; o_valid 0 on every other cycle.
- Negative operand and back-to-back streaming:
  - Input sequence 0xFE80 (-1.5), 0x0180 (1.5), 0x0000 on consecutive cycles -> consecutive outputs 0x0240, 0x0240, 0x0000 with o_valid held high for 3 cycles.
- Overflow:
  - in=0x0C00 (12.0) -> 144 out of range: upflow=1, out=0x7FFF with ROOF=1.
  - in=0x8000 (-128) -> upflow=1, out=0x7FFF.
  - With ROOF=0, in=0x0C00 -> out=0x9000, upflow=1.
- Rounding and underflow:
  - in=0x000C (exact 144/65536): ROUND=1 -> out=0x0001, downflow=0; ROUND=0 -> out=0x0000, downflow=1.
  - in=0x0001 -> out=0x0000, downflow=1 for either ROUND setting.
- Reset mid-stream:
  - Issue 5 valid samples, assert rst for 1 cycle 3 clocks later -> outputs drop to 0 asynchronously and no o_valid appears for the flushed samples.
  - A sample issued after release (in=0x0200) -> out=0x0400 after 18 clocks.
- Bubbles:
  - Alternate i_valid 1/0 with in=0x0100 -> o_valid toggles 1/0 with out=0x0100 on valid cycles; upflow/downflow stay 0 throughout.
